// File: rtl/mem_pkg.sv
// Shared types and constants for the MIPS memory stage (mem_stage and mem_wb_reg).
package mem_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    localparam int M_BRANCH    = 2;
    localparam int M_READ      = 1;
    localparam int M_WRITE     = 0;
    localparam int WB_MEM2REG  = 1;
    localparam int WB_REGWRITE = 0;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    function automatic logic is_memop(input logic [2:0] m);
        return m[M_READ] | m[M_WRITE];
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: full load, or bubble insert that clears only the control bits.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] res_i,
    input  logic [4:0]  wreg_i,
    input  logic [1:0]  wb_i,
    output logic [31:0] rdata_o,
    output logic [31:0] res_o,
    output logic [4:0]  wreg_o,
    output logic [1:0]  wb_o
);

    logic [31:0] rdata_q;
    logic [31:0] res_q;
    logic [4:0]  wreg_q;
    logic [1:0]  wb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            res_q   <= '0;
            wreg_q  <= '0;
            wb_q    <= '0;
        end else if (load_i) begin
            rdata_q <= rdata_i;
            res_q   <= res_i;
            wreg_q  <= wreg_i;
            wb_q    <= wb_i;
        end else if (bubble_i) begin
            // A bubble must never write the register file; data fields keep their value.
            wb_q[WB_MEM2REG]  <= 1'b0;
            wb_q[WB_REGWRITE] <= 1'b0;
        end
    end

    assign rdata_o = rdata_q;
    assign res_o   = res_q;
    assign wreg_o  = wreg_q;
    assign wb_o    = wb_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM -> data-memory req/ack bus -> MEM/WB, with upstream stall.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       res,
    input  logic [31:0]       write_data_ex,
    input  logic [4:0]        write_register_ex,
    input  logic              zero,
    input  logic [2:0]        m_MEM,
    input  logic [1:0]        wb_MEM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic              pcsrc,
    output logic [31:0]       read_data_wb,
    output logic [31:0]       res_wb,
    output logic [4:0]        write_register_wb,
    output logic [1:0]        wb_WB,
    output logic              bus_error,
    output state_e            state_dbg
);

    if (TIMEOUT_CYCLES < 1 || ADDR_W < 1 || ADDR_W > 30) begin : g_bad_params
        $error("mem_stage: unsupported ADDR_W or TIMEOUT_CYCLES");
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                mw_load, mw_bubble, stall_c, timeout_hit;
    logic [31:0]         mw_rdata;
    logic [1:0]          mw_wb;

    // Handshake: dmem_req rises the cycle after a memop is seen in IDLE and stays high,
    // with addr/wdata/we frozen, until a one-cycle dmem_ack (or a timeout) ends it.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        mw_load   = 1'b0;
        mw_bubble = 1'b0;
        mw_rdata  = '0;
        mw_wb     = wb_MEM;
        stall_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_memop(m_MEM)) begin
                    stall_c   = 1'b1;
                    mw_bubble = 1'b1;
                    state_d   = REQ;
                    addr_d    = res[ADDR_W+1:2];
                    wdata_d   = write_data_ex;
                    we_d      = m_MEM[M_WRITE];
                end else begin
                    mw_load = 1'b1;
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    mw_load  = 1'b1;
                    mw_rdata = we_q ? 32'd0 : dmem_rdata;
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    mw_load  = 1'b1;
                    mw_rdata = TIMEOUT_DATA;
                    mw_wb    = 2'b00;
                    state_d  = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    // cnt_q counts REQ cycles already spent; the last allowed cycle aborts if no ack.
    assign timeout_hit = (state_q == REQ) && !dmem_ack &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d     = '0;
        bus_err_d = bus_err_q | timeout_hit;
        if (state_q == REQ && !dmem_ack && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_error = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_error   = 1'b0;
`endif

    mem_wb_reg u_mem_wb (
        .clk      (clk),
        .reset    (reset),
        .load_i   (mw_load),
        .bubble_i (mw_bubble),
        .rdata_i  (mw_rdata),
        .res_i    (res),
        .wreg_i   (write_register_ex),
        .wb_i     (mw_wb),
        .rdata_o  (read_data_wb),
        .res_o    (res_wb),
        .wreg_o   (write_register_wb),
        .wb_o     (wb_WB)
    );

    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign stall      = stall_c & ~reset;
    assign pcsrc      = m_MEM[M_BRANCH] & zero;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan cases plus randomized traffic
// against a transaction-level model of the MEM/WB register.
module tb_mem_stage;
    import mem_pkg::*;

    localparam int ADDR_W         = 8;
    localparam int TIMEOUT_CYCLES = 16;

    logic              clk;
    logic              reset;
    logic [31:0]       res;
    logic [31:0]       write_data_ex;
    logic [4:0]        write_register_ex;
    logic              zero;
    logic [2:0]        m_MEM;
    logic [1:0]        wb_MEM;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;
    logic              stall;
    logic              pcsrc;
    logic [31:0]       read_data_wb;
    logic [31:0]       res_wb;
    logic [4:0]        write_register_wb;
    logic [1:0]        wb_WB;
    logic              bus_error;
    state_e            state_dbg;

    mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk               (clk),
        .reset             (reset),
        .res               (res),
        .write_data_ex     (write_data_ex),
        .write_register_ex (write_register_ex),
        .zero              (zero),
        .m_MEM             (m_MEM),
        .wb_MEM            (wb_MEM),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_rdata        (dmem_rdata),
        .dmem_ack          (dmem_ack),
        .stall             (stall),
        .pcsrc             (pcsrc),
        .read_data_wb      (read_data_wb),
        .res_wb            (res_wb),
        .write_register_wb (write_register_wb),
        .wb_WB             (wb_WB),
        .bus_error         (bus_error),
        .state_dbg         (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // MEM/WB model: what the register must hold after each edge, as {rdata,res,wreg,wb}.
    logic [31:0] m_rd;
    logic [31:0] m_res;
    logic [4:0]  m_wreg;
    logic [1:0]  m_wb;
    logic        m_bus_err;
    logic [70:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_rd = '0; m_res = '0; m_wreg = '0; m_wb = '0; m_bus_err = 1'b0;
    endtask

    task automatic model_push();
        exp_q.push_back({m_rd, m_res, m_wreg, m_wb});
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [70:0] act;
        reset = 1'b1;
        res = '0; write_data_ex = '0; write_register_ex = '0; zero = 1'b0;
        m_MEM = '0; wb_MEM = '0; dmem_rdata = '0; dmem_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        model_reset();
        act = {read_data_wb, res_wb, write_register_wb, wb_WB};
        n_cmp++; if (act !== 71'd0) begin n_fail++; $display("FAIL reset_mem_wb: got %h expected 0", act); end
        n_cmp++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== '0) begin n_fail++;
            $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h expected all 0", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
        n_cmp++; if ({stall, pcsrc, bus_error} !== 3'b000) begin n_fail++;
            $display("FAIL reset_flags: got stall=%b pcsrc=%b bus_error=%b expected 000", stall, pcsrc, bus_error); end
        n_cmp++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %b expected IDLE", state_dbg); end
    endtask

    // Non-memory instructions; an ack on the bus in IDLE must be ignored.
    task automatic test_rtype(input int n);
        logic [31:0] r;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic        br, z;
        logic [70:0] e;
        for (int i = 0; i < n; i++) begin
            r  = (i == 0) ? 32'h15 : $urandom;
            wr = (i == 0) ? 5'd3 : 5'($urandom_range(0, 31));
            wb = (i == 0) ? 2'b01 : 2'($urandom_range(0, 3));
            br = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            res = r; write_register_ex = wr; wb_MEM = wb; zero = z;
            m_MEM = {br, 2'b00};
            write_data_ex = $urandom;
            dmem_ack = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            @(negedge clk);
            n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rtype_stall: got %b expected 0", stall); end
            n_cmp++; if (pcsrc !== (br & z)) begin n_fail++; $display("FAIL rtype_pcsrc: got %b expected %b", pcsrc, br & z); end
            n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rtype_req: got %b expected 0", dmem_req); end
            tick();
            m_rd = '0; m_res = r; m_wreg = wr; m_wb = wb;
            model_push();
            e = exp_q.pop_front();
            n_cmp++; if ({read_data_wb, res_wb, write_register_wb, wb_WB} !== e) begin n_fail++;
                $display("FAIL rtype_mem_wb: got %h expected %h", {read_data_wb, res_wb, write_register_wb, wb_WB}, e); end
        end
        dmem_ack = 1'b0;
        m_MEM = '0;
    endtask

    // One load/store: bubble at the first edge, then waits+1 REQ cycles with ack in the last.
    task automatic run_memop(input logic [2:0] m, input logic [31:0] r, input logic [31:0] wd,
                             input logic [4:0] wr, input logic [1:0] wb, input int waits,
                             input logic [31:0] rd, input string tag);
        logic [70:0] e;
        logic        exp_stall;
        logic [ADDR_W-1:0] exp_addr;
        exp_addr = r[ADDR_W+1:2];
        m_MEM = m; res = r; write_data_ex = wd; write_register_ex = wr; wb_MEM = wb;
        zero = 1'($urandom_range(0, 1));
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        @(negedge clk);
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall_c0: got %b expected 1", tag, stall); end
        n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL %s_req_c0: got %b expected 0", tag, dmem_req); end
        tick();
        m_wb = 2'b00;
        model_push();
        e = exp_q.pop_front();
        n_cmp++; if ({read_data_wb, res_wb, write_register_wb, wb_WB} !== e) begin n_fail++;
            $display("FAIL %s_bubble: got %h expected %h", tag, {read_data_wb, res_wb, write_register_wb, wb_WB}, e); end
        for (int i = 0; i <= waits; i++) begin
            dmem_ack   = (i == waits);
            dmem_rdata = (i == waits) ? rd : $urandom;
            exp_stall  = (i != waits);
            @(negedge clk);
            n_cmp++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL %s_req: got %b expected 1 (req cycle %0d)", tag, dmem_req, i); end
            n_cmp++; if ({dmem_we, dmem_addr, dmem_wdata} !== {m[0], exp_addr, wd}) begin n_fail++;
                $display("FAIL %s_bus: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                         tag, dmem_we, dmem_addr, dmem_wdata, m[0], exp_addr, wd); end
            n_cmp++; if (stall !== exp_stall) begin n_fail++; $display("FAIL %s_stall: got %b expected %b (req cycle %0d)", tag, stall, exp_stall, i); end
            tick();
        end
        dmem_ack = 1'b0;
        m_MEM = '0;
        m_rd = m[0] ? 32'd0 : rd; m_res = r; m_wreg = wr; m_wb = wb;
        model_push();
        e = exp_q.pop_front();
        n_cmp++; if ({read_data_wb, res_wb, write_register_wb, wb_WB} !== e) begin n_fail++;
            $display("FAIL %s_result: got %h expected %h", tag, {read_data_wb, res_wb, write_register_wb, wb_WB}, e); end
        n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL %s_req_drop: got %b expected 0", tag, dmem_req); end
    endtask

    task automatic test_load_immediate();
        run_memop(3'b010, 32'h40, $urandom, 5'd7, 2'b11, 0, 32'hCAFE0001, "load_imm");
    endtask

    task automatic test_store_wait();
        run_memop(3'b001, 32'h0000_0104, 32'h1234, 5'd9, 2'b00, 3, $urandom, "store_w3");
    endtask

    task automatic test_back_to_back();
        run_memop(3'b010, $urandom, $urandom, 5'd1, 2'b11, 1, $urandom, "b2b_first");
        run_memop(3'b010, $urandom, $urandom, 5'd2, 2'b11, 0, $urandom, "b2b_second");
        run_memop(3'b011, $urandom, $urandom, 5'd4, 2'b01, 2, $urandom, "b2b_rw");
    endtask

    task automatic test_random(input int n);
        logic [2:0] m;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                test_rtype(1 + $urandom_range(0, 1));
            end else begin
                m = {1'b0, 2'($urandom_range(1, 3))};
                run_memop(m, $urandom, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                          $urandom_range(0, 4), $urandom, "rand");
            end
        end
    endtask

    task automatic test_branch();
        m_MEM = 3'b100; zero = 1'b1; dmem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (pcsrc !== 1'b1) begin n_fail++; $display("FAIL branch_taken: got %b expected 1", pcsrc); end
        zero = 1'b0;
        #1;
        n_cmp++; if (pcsrc !== 1'b0) begin n_fail++; $display("FAIL branch_not_taken: got %b expected 0", pcsrc); end
        m_MEM = 3'b000; zero = 1'b1;
        #1;
        n_cmp++; if (pcsrc !== 1'b0) begin n_fail++; $display("FAIL branch_no_branch: got %b expected 0", pcsrc); end
        tick();
        m_rd = '0; m_res = res; m_wreg = write_register_ex; m_wb = wb_MEM;
        model_push();
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] r2;
        logic [4:0]  wr2;
        logic [70:0] e;
        m_MEM = 3'b010; res = $urandom; write_register_ex = 5'd12; wb_MEM = 2'b11; dmem_ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req_before: got %b expected 1", dmem_req); end
        tick();
        reset = 1'b0;
        model_reset();
        r2 = $urandom; wr2 = 5'($urandom_range(0, 31));
        m_MEM = '0; wb_MEM = 2'b00; res = r2; write_register_ex = wr2;
        dmem_ack = 1'b1; dmem_rdata = $urandom;
        @(negedge clk);
        n_cmp++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b expected 0", dmem_req); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b expected 0", stall); end
        n_cmp++; if ({wb_WB, read_data_wb, dmem_addr} !== '0) begin n_fail++;
            $display("FAIL rst_mid_regs: got wb=%b rdata=%h addr=%h expected 0", wb_WB, read_data_wb, dmem_addr); end
        n_cmp++; if (bus_error !== m_bus_err) begin n_fail++; $display("FAIL rst_mid_bus_error: got %b expected %b", bus_error, m_bus_err); end
        tick();
        dmem_ack = 1'b0;
        m_rd = '0; m_res = r2; m_wreg = wr2; m_wb = 2'b00;
        model_push();
        e = exp_q.pop_front();
        n_cmp++; if ({read_data_wb, res_wb, write_register_wb, wb_WB} !== e) begin n_fail++;
            $display("FAIL rst_late_ack: got %h expected %h", {read_data_wb, res_wb, write_register_wb, wb_WB}, e); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] r;
        logic [4:0]  wr;
        logic [70:0] e;
        logic        exp_stall;
        r = $urandom; wr = 5'($urandom_range(0, 31));
        m_MEM = 3'b010; res = r; write_register_ex = wr; wb_MEM = 2'b11; dmem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL to_stall_c0: got %b expected 1", stall); end
        tick();
        m_wb = 2'b00;
        model_push();
        e = exp_q.pop_front();
        n_cmp++; if ({read_data_wb, res_wb, write_register_wb, wb_WB} !== e) begin n_fail++;
            $display("FAIL to_bubble: got %h expected %h", {read_data_wb, res_wb, write_register_wb, wb_WB}, e); end
        for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
            exp_stall = (i != TIMEOUT_CYCLES - 1);
            @(negedge clk);
            n_cmp++; if ({dmem_req, stall, bus_error} !== {1'b1, exp_stall, 1'b0}) begin n_fail++;
                $display("FAIL to_wait: got req=%b stall=%b err=%b expected 1%b0 (req cycle %0d)", dmem_req, stall, bus_error, exp_stall, i); end
            tick();
        end
        m_MEM = '0;
        m_rd = TIMEOUT_DATA; m_res = r; m_wreg = wr; m_wb = 2'b00; m_bus_err = 1'b1;
        model_push();
        e = exp_q.pop_front();
        n_cmp++; if ({read_data_wb, res_wb, write_register_wb, wb_WB} !== e) begin n_fail++;
            $display("FAIL to_result: got %h expected %h", {read_data_wb, res_wb, write_register_wb, wb_WB}, e); end
        n_cmp++; if ({dmem_req, bus_error} !== {1'b0, m_bus_err}) begin n_fail++;
            $display("FAIL to_abort: got req=%b err=%b expected req=0 err=1", dmem_req, bus_error); end
        test_rtype(3);
        run_memop(3'b010, $urandom, $urandom, 5'd5, 2'b11, 1, $urandom, "after_to");
        n_cmp++; if (bus_error !== m_bus_err) begin n_fail++; $display("FAIL to_sticky: got %b expected %b", bus_error, m_bus_err); end
    endtask
`else
    task automatic test_timeout();
        run_memop(3'b010, $urandom, $urandom, 5'd6, 2'b11, TIMEOUT_CYCLES + 4, $urandom, "no_to");
        n_cmp++; if (bus_error !== m_bus_err) begin n_fail++; $display("FAIL no_to_bus_error: got %b expected %b", bus_error, m_bus_err); end
    endtask
`endif

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_rtype(6);
        test_load_immediate();
        test_store_wait();
        test_branch();
        test_back_to_back();
        test_random(30);
        test_timeout();
        test_reset_mid_req();
        test_rtype(3);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
